// File: rtl/cpu_stream_mux.sv
// cpu_stream_mux: N-channel stream concentrator.
// Per-channel FIFOs feed a round-robin arbiter. The arbiter loads one
// registered output beat tagged {channel, payload}. all_done is raised once
// every channel has reported done and all buffered traffic has drained.
// Optional feature macro: CPU_STREAM_MUX_STATS_EN adds per-channel
// accepted-beat counters on stats_count. Without it, stats_count is tied to 0.
module cpu_stream_mux #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            in_data_vld,
    output logic [N_CH-1:0]            in_data_rdy,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]            in_done,
    output logic                       out_data_vld,
    input  logic                       out_data_rdy,
    output logic [DATA_WIDTH+7:0]      out_data,
    output logic                       all_done,
    output logic [N_CH*32-1:0]         stats_count
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned RR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW    = RR_W + 1;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned CNT_W = 32;

    // Parameter sanity: reject unsupported configurations at elaboration
    if (N_CH < 1 || N_CH > 256) begin : g_bad_nch
        $error("cpu_stream_mux: N_CH must be in 1..256");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cpu_stream_mux: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    logic [N_CH-1:0]       fifo_full;
    logic [N_CH-1:0]       fifo_empty;
    logic [N_CH-1:0]       push;
    logic [N_CH-1:0]       pop;
    logic [DATA_WIDTH-1:0] head [N_CH];

    logic [RR_W-1:0] rr;
    logic [RR_W-1:0] grant;
    logic [CW-1:0]   cand;
    logic            any_valid;
    logic            load;
    out_state_e      state_q;
    out_state_e      state_d;
    logic [N_CH-1:0] done_seen;

    assign any_valid    = |(~fifo_empty);
    assign out_data_vld = (state_q == ST_FULL);
    assign in_data_rdy  = ~fifo_full;

    // Per-channel FIFO: pointers one bit wider than the address, MSB disambiguates full/empty
    for (genvar i = 0; i < N_CH; i++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]         wr_ptr;
        logic [PW-1:0]         rd_ptr;

        assign fifo_empty[i] = (wr_ptr == rd_ptr);
        assign fifo_full[i]  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        assign push[i]       = in_data_vld[i] && !fifo_full[i];
        assign pop[i]        = load && (grant == RR_W'(i));
        assign head[i]       = mem[rd_ptr[AW-1:0]];

        // Pointer update; a pop only ever targets a non-empty FIFO
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[i]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end

        // Storage write; contents need no reset because the pointers gate visibility
        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem[wr_ptr[AW-1:0]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: scan downward so the lowest offset from rr wins
    always_comb begin
        grant = '0;
        cand  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = {1'b0, rr} + CW'(k);
            if (cand >= CW'(N_CH)) begin
                cand = cand - CW'(N_CH);
            end
            if (!fifo_empty[RR_W'(cand)]) begin
                grant = RR_W'(cand);
            end
        end
    end

    // Output register state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output next state and load decision; a FULL register reloads on the accepting edge
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (any_valid) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_data_rdy) begin
                    if (any_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output payload register: {zero-extended channel index, payload}
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= {IDX_W'(grant), head[grant]};
        end
    end

    // Round-robin pointer advances past the granted channel on each load
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (load) begin
            rr <= (grant == RR_W'(N_CH - 1)) ? '0 : grant + RR_W'(1);
        end
    end

    // Sticky per-channel done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            done_seen <= '0;
        end else begin
            done_seen <= done_seen | in_done;
        end
    end

    // Completion level: set once everything has drained, held until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            all_done <= 1'b0;
        end else if ((&done_seen) && (&fifo_empty) && (state_q == ST_EMPTY)) begin
            all_done <= 1'b1;
        end
    end

`ifdef CPU_STREAM_MUX_STATS_EN
    // Accepted-beat counters, wrapping at 2^32
    for (genvar i = 0; i < N_CH; i++) begin : g_stats
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (push[i]) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign stats_count[i*CNT_W +: CNT_W] = cnt;
    end
`else
    assign stats_count = '0;
`endif

endmodule

// File: tb/tb_cpu_stream_mux.sv
// Self-checking bench for cpu_stream_mux (N_CH=4, DATA_WIDTH=64, FIFO_DEPTH=4).
// Beats are pushed to a scoreboard as they are accepted. They are popped in
// per-channel order as the DUT emits them.
`timescale 1ns/1ps
module tb_cpu_stream_mux;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DW   = 64;
    localparam int unsigned FD   = 4;
    localparam int unsigned OW   = DW + 8;
`ifdef CPU_STREAM_MUX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   in_data_vld;
    logic [N_CH-1:0]   in_data_rdy;
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]   in_done;
    logic              out_data_vld;
    logic              out_data_rdy;
    logic [OW-1:0]     out_data;
    logic              all_done;
    logic [N_CH*32-1:0] stats_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int seq = 0;
    int last_xfer_edge = 0;
    int mon_idx;
    logic [OW-1:0] exp_q[$];
    int ch_seen[$];
    int xfer_cyc[$];
    logic stall_q = 1'b0;
    logic [OW-1:0] stall_data = '0;

    cpu_stream_mux #(
        .N_CH(N_CH),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data_vld(in_data_vld),
        .in_data_rdy(in_data_rdy),
        .in_data(in_data),
        .in_done(in_done),
        .out_data_vld(out_data_vld),
        .out_data_rdy(out_data_rdy),
        .out_data(out_data),
        .all_done(all_done),
        .stats_count(stats_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_vld", OW'(out_data_vld), OW'(1));
                check("hold_data", out_data, stall_data);
            end
            for (int i = 0; i < N_CH; i++) begin
                if (in_data_vld[i] && in_data_rdy[i]) begin
                    exp_q.push_back({8'(i), in_data[i*DW +: DW]});
                end
            end
            if (out_data_vld && out_data_rdy) begin
                mon_idx = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (mon_idx < 0 && exp_q[k][OW-1:DW] == out_data[OW-1:DW]) begin
                        mon_idx = k;
                    end
                end
                check("sb_found", OW'(mon_idx >= 0), OW'(1));
                if (mon_idx >= 0) begin
                    check("sb_data", out_data, exp_q[mon_idx]);
                    exp_q.delete(mon_idx);
                end
                ch_seen.push_back(int'(out_data[OW-1:DW]));
                xfer_cyc.push_back(cyc);
                last_xfer_edge = cyc + 1;
            end
            stall_q    = out_data_vld && !out_data_rdy;
            stall_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || out_data_vld) && t < budget) begin
            tick();
            t++;
        end
        check("drain", OW'(exp_q.size() == 0 && !out_data_vld), OW'(1));
    endtask

    task automatic send_burst(input int ch, input int n, input int budget);
        int sent = 0;
        int t = 0;
        logic acc;
        while (sent < n && t < budget) begin
            in_data_vld[ch] = 1'b1;
            in_data[ch*DW +: DW] = {32'(ch), 32'(seq)};
            acc = in_data_rdy[ch];
            tick();
            t++;
            if (acc) begin
                sent++;
                seq++;
            end
        end
        in_data_vld[ch] = 1'b0;
        check("burst_sent", OW'(sent), OW'(n));
    endtask

    task automatic run_multi(input logic [N_CH-1:0] mask, input int beats, input int budget);
        int left [N_CH];
        int pend;
        int t = 0;
        logic [N_CH-1:0] acc;
        pend = 0;
        for (int i = 0; i < N_CH; i++) begin
            left[i] = mask[i] ? beats : 0;
            pend += left[i];
        end
        while (pend > 0 && t < budget) begin
            for (int i = 0; i < N_CH; i++) begin
                in_data_vld[i] = (left[i] > 0);
                in_data[i*DW +: DW] = {16'(seq), 16'(i), 32'(left[i])};
            end
            acc = in_data_vld & in_data_rdy;
            tick();
            t++;
            pend = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (acc[i]) left[i]--;
                pend += left[i];
            end
        end
        in_data_vld = '0;
        seq++;
        check("multi_sent", OW'(pend), OW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc_n;
        int t;
        int seq0;
        logic acc;

        rst          = 1'b1;
        in_data_vld  = '0;
        in_data      = '0;
        in_done      = '0;
        out_data_rdy = 1'b1;
        do_reset(3);

        // Reset values
        check("rst_rdy", OW'(in_data_rdy), OW'(4'hF));
        check("rst_vld", OW'(out_data_vld), OW'(0));
        check("rst_data", out_data, OW'(0));
        check("rst_done", OW'(all_done), OW'(0));
        check("rst_stats", OW'(stats_count), OW'(0));

        // Single beat on ch2, two-cycle latency, one-cycle pulse
        in_data[2*DW +: DW] = 64'hDEAD_BEEF;
        in_data_vld[2] = 1'b1;
        tick();
        in_data_vld[2] = 1'b0;
        check("t1_early", OW'(out_data_vld), OW'(0));
        tick();
        check("t1_vld", OW'(out_data_vld), OW'(1));
        check("t1_data", out_data, {8'h02, 64'hDEAD_BEEF});
        tick();
        check("t1_pulse", OW'(out_data_vld), OW'(0));

        // Fairness: all channels valid, order 0,1,2,3,... with no bubbles
        do_reset(1);
        ch_seen.delete();
        xfer_cyc.delete();
        run_multi(4'hF, 8, 200);
        wait_drain(100);
        check("fair_count", OW'(ch_seen.size()), OW'(32));
        if (ch_seen.size() >= 16) begin
            for (int k = 0; k < 16; k++) begin
                check("fair_order", OW'(ch_seen[k]), OW'(k % 4));
                if (k > 0) check("fair_gap", OW'(xfer_cyc[k] - xfer_cyc[k-1]), OW'(1));
            end
        end

        // Backpressure on ch0: 5 accepted while stalled, 6th after release
        out_data_rdy = 1'b0;
        acc_n = 0;
        seq0 = seq;
        in_data_vld[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data[0 +: DW] = {32'h0, 32'(seq)};
            acc = in_data_rdy[0];
            tick();
            if (acc) begin
                acc_n++;
                seq++;
            end
        end
        check("bp_accepted", OW'(acc_n), OW'(5));
        check("bp_rdy_low", OW'(in_data_rdy[0]), OW'(0));
        check("bp_head", out_data, {8'h00, 32'h0, 32'(seq0)});
        out_data_rdy = 1'b1;
        t = 0;
        while (acc_n < 6 && t < 20) begin
            in_data[0 +: DW] = {32'h0, 32'(seq)};
            acc = in_data_rdy[0];
            tick();
            t++;
            if (acc) begin
                acc_n++;
                seq++;
            end
        end
        in_data_vld[0] = 1'b0;
        check("bp_sixth", OW'(acc_n), OW'(6));
        wait_drain(50);

        // Completion: 3 beats per channel, then a one-cycle done pulse
        check("cd_pre", OW'(all_done), OW'(0));
        run_multi(4'hF, 3, 100);
        in_done = 4'hF;
        tick();
        in_done = '0;
        check("cd_not_early", OW'(all_done), OW'(0));
        t = 0;
        while (!all_done && t < 60) begin
            tick();
            t++;
        end
        check("cd_rise", OW'(all_done), OW'(1));
        check("cd_edge", OW'(cyc), OW'(last_xfer_edge + 1));
        check("cd_empty", OW'(exp_q.size()), OW'(0));
        repeat (5) tick();
        check("cd_hold", OW'(all_done), OW'(1));
        send_burst(1, 1, 20);
        wait_drain(20);
        check("cd_late", OW'(all_done), OW'(1));

        // Mid-run reset with beats buffered on ch2 (leaves rr non-zero)
        out_data_rdy = 1'b0;
        in_data[2*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        in_data_vld[2] = 1'b1;
        repeat (3) tick();
        in_data_vld = '0;
        check("mr_pre_vld", OW'(out_data_vld), OW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_vld", OW'(out_data_vld), OW'(0));
        check("mr_rdy", OW'(in_data_rdy), OW'(4'hF));
        check("mr_done", OW'(all_done), OW'(0));
        check("mr_stats", OW'(stats_count), OW'(0));
        out_data_rdy = 1'b1;
        ch_seen.delete();
        run_multi(4'b1010, 1, 20);
        wait_drain(20);
        check("mr_count", OW'(ch_seen.size()), OW'(2));
        check("mr_rr_restart", OW'(ch_seen.size() > 0 ? ch_seen[0] : 255), OW'(1));

        // Statistics: ch1 sends 10 beats
        do_reset(1);
        send_burst(1, 10, 100);
        wait_drain(50);
        for (int i = 0; i < N_CH; i++) begin
            check("stats", OW'(stats_count[i*32 +: 32]), OW'((STATS_ON && i == 1) ? 10 : 0));
        end

        check("sb_empty", OW'(exp_q.size()), OW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_stream_mux.md
# cpu_stream_mux

Parametrised N-channel stream concentrator between multiple `cpu` traffic generators and a single `multisim_client`. Each channel has its own `data_vld`/`data_rdy`/`data` input, buffered in a per-channel FIFO. A round-robin arbiter merges the buffered beats into one registered output stream, with each beat tagged by its source channel. The block also reports completion: `all_done` rises once every channel has signalled done and all buffered traffic has drained, so the top level can `$finish` from one signal.

## Interface
- `N_CH`, 4: number of input channels, 1..256.
- `DATA_WIDTH`, 64: payload width per beat.
- `FIFO_DEPTH`, 4: entries per channel FIFO; power of 2, ≥2.
- `clk` input 1: single clock, all state on posedge.
- `rst` input 1: synchronous, active-high reset.
- `in_data_vld` input N_CH: per-channel beat valid.
- `in_data_rdy` output N_CH: per-channel ready, equals `!fifo_full[i]`.
- `in_data` input N_CH*DATA_WIDTH: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_done` input N_CH: channel i has no more traffic; sampled and made sticky.
- `out_data_vld` output 1: output beat valid (registered).
- `out_data_rdy` input 1: downstream ready.
- `out_data` output DATA_WIDTH+8: {8-bit channel index, payload} (registered).
- `all_done` output 1: completion level (registered).
- `stats_count` output N_CH*32: per-channel accepted-beat counters; see Configuration.

## Operation
- Transfer rule on every interface: a beat moves on a posedge where vld && rdy.
- Input side:
  - Push into FIFO i on in_data_vld[i] && in_data_rdy[i].
  - `in_data_rdy` depends only on registered FIFO occupancy; there is no combinational path from `out_data_rdy` to `in_data_rdy`.
- Output register states:
  - EMPTY: out_data_vld=0.
  - FULL: out_data_vld=1; `out_data` holds stable until accepted.
- Load condition: the output register loads when (EMPTY or out_data_rdy) and at least one FIFO is non-empty.
- Arbitration:
  - Round-robin starting from pointer `rr`; the grant goes to the first non-empty FIFO at index ≥ rr, wrapping.
  - On a load, the granted FIFO is popped and `rr` becomes (grant+1) mod N_CH.
  - With no load, `rr` holds.
- Completion:
  - `done_seen[i]` sets when in_done[i]=1 and clears only on reset.
  - `all_done` is registered high when &done_seen, all FIFOs are empty and out_data_vld=0.
  - Once set, `all_done` stays high until reset.
  - Beats presented after in_done are still accepted. `all_done` deasserts only via reset; it does not drop because of late beats.
- Channel index field: zero-extended to 8 bits.

## Timing
- Reset values:
  - in_data_rdy = all 1s, out_data_vld = 0, out_data = 0, all_done = 0, stats_count = 0.
  - rr = 0, FIFOs empty, done_seen = 0.
- Latency: a beat accepted at edge t is visible on out_data_vld/out_data in the cycle after edge t+1 (2 cycles), provided the output register is free and the channel wins arbitration.
- Throughput: 1 beat/cycle aggregate when out_data_rdy is held high.
- Back-to-back: while FULL, a new beat loads on the same edge as the downstream acceptance, with no bubble.
- FIFO full: in_data_rdy[i]=0 in the cycle after the push that fills it. A pop and a push on the same edge are allowed when the FIFO is not full.
- FIFO empty: a push and an arbiter read cannot coincide on an empty FIFO. A beat written at edge t becomes eligible only from cycle t+1.
- Pointers: FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty are decoded from the MSB.
- Reset mid-operation: all FIFO contents are discarded, out_data_vld=0 from the next cycle, and in-flight beats are lost.

## Configuration
- Macro: `CPU_STREAM_MUX_STATS_EN`.
- Defined:
  - `stats_count[i]` is a 32-bit counter incremented on each accepted input beat of channel i.
  - It wraps at 2^32 and resets to 0.
- Undefined:
  - No counters are instantiated; `stats_count` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- Single beat: N_CH=4, ch2 sends 0xDEAD_BEEF with out_data_rdy=1 -> out_data={8'h02, 64'hDEAD_BEEF}, out_data_vld high exactly 2 cycles after acceptance, for 1 cycle.
- Fairness: all 4 channels continuously valid, out_data_rdy=1 -> output channel order 0,1,2,3,0,1,… with no bubbles after the first beat.
- Backpressure: out_data_rdy=0 while ch0 sends 6 beats, FIFO_DEPTH=4 ->
  - in_data_rdy[0] drops after 5 accepted beats (4 in the FIFO plus 1 in the output register).
  - out_data stays stable.
  - Releasing ready delivers the 5 beats in order.
  - The 6th beat is accepted as space frees.
- Completion: each channel sends 3 beats, then in_done is pulsed one cycle -> all_done rises the cycle after the last output beat is accepted and stays high.
- Mid-run reset: rst is asserted for 1 cycle with beats buffered ->
  - Next cycle: out_data_vld=0, in_data_rdy all 1s.
  - rr restarts at 0.
  - all_done=0.
  - stats_count=0.
- Stats build: with `CPU_STREAM_MUX_STATS_EN` defined, ch1 sends 10 beats -> stats_count[1]=10 and all other counters 0. With the macro undefined, all counters read 0.
